// File: rtl/decoded_instruction_queue.sv
// decoded_instruction_queue: circular FIFO between the instruction format
// decoder and the register-read/issue stage. The head entry is offered with
// valid/ready. stall_o is raised early so the upstream pipeline, which has no
// backpressure of its own, can stop issuing before entries are lost.
module decoded_instruction_queue #(
  parameter int addressSize      = 64,
  parameter int opcodeWidth      = 6,
  parameter int xOpCodeWidth     = 10,
  parameter int formatIndexRange = 5,
  parameter int regWidth         = 5,
  parameter int immWidth         = 16,
  parameter int depthLog2        = 3,
  parameter int skidSlots        = 2
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        enable_i,
  input  logic [opcodeWidth-1:0]      opCode_i,
  input  logic [xOpCodeWidth-1:0]     xOpCode_i,
  input  logic [addressSize-1:0]      address_i,
  input  logic [formatIndexRange-1:0] instructionFormat_i,
  input  logic [regWidth-1:0]         reg1_i,
  input  logic [regWidth-1:0]         reg2_i,
  input  logic [regWidth-1:0]         reg3_i,
  input  logic [immWidth-1:0]         imm_i,
  input  logic                        bit1_i,
  input  logic                        bit2_i,
  input  logic                        flush_i,
  input  logic                        readReady_i,
  output logic                        enable_o,
  output logic [opcodeWidth-1:0]      opCode_o,
  output logic [xOpCodeWidth-1:0]     xOpCode_o,
  output logic [addressSize-1:0]      address_o,
  output logic [formatIndexRange-1:0] instructionFormat_o,
  output logic [regWidth-1:0]         reg1_o,
  output logic [regWidth-1:0]         reg2_o,
  output logic [regWidth-1:0]         reg3_o,
  output logic [immWidth-1:0]         imm_o,
  output logic                        bit1_o,
  output logic                        bit2_o,
  output logic                        stall_o,
  output logic [depthLog2:0]          count_o,
  output logic                        overflow_o
);

  localparam int DEPTH = 1 << depthLog2;
  localparam logic [depthLog2:0] FULL_C  = (depthLog2+1)'(DEPTH);
  localparam logic [depthLog2:0] STALL_C = (depthLog2+1)'(DEPTH - skidSlots);

  typedef struct packed {
    logic [opcodeWidth-1:0]      op_code;
    logic [xOpCodeWidth-1:0]     x_op_code;
    logic [addressSize-1:0]      address;
    logic [formatIndexRange-1:0] format;
    logic [regWidth-1:0]         reg1;
    logic [regWidth-1:0]         reg2;
    logic [regWidth-1:0]         reg3;
    logic [immWidth-1:0]         imm;
    logic                        bit1;
    logic                        bit2;
  } entry_t;

  entry_t                 mem_q [DEPTH];
  entry_t                 mem_d [DEPTH];
  logic [depthLog2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [depthLog2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [depthLog2:0]     count_q, count_d;
  logic                   overflow_q, overflow_d;

  entry_t entry_in;
  entry_t head;
  logic   push;
  logic   pop;
  logic   full;

  assign entry_in = '{op_code:   opCode_i,
                      x_op_code: xOpCode_i,
                      address:   address_i,
                      format:    instructionFormat_i,
                      reg1:      reg1_i,
                      reg2:      reg2_i,
                      reg3:      reg3_i,
                      imm:       imm_i,
                      bit1:      bit1_i,
                      bit2:      bit2_i};

  // Next-state: push/pop bookkeeping, flush overrides everything.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = 1'b0;
    full       = (count_q == FULL_C);
    // No bypass: an empty queue never pops, even with a push this cycle.
    pop        = (count_q != '0) && readReady_i;
    push       = enable_i && (!full || pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = entry_in;
        wr_ptr_d        = wr_ptr_q + depthLog2'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + depthLog2'(1);
      end
      if (push && !pop) begin
        count_d = count_q + (depthLog2+1)'(1);
      end else if (pop && !push) begin
        count_d = count_q - (depthLog2+1)'(1);
      end
      overflow_d = enable_i && !push;
    end
  end

  // State registers; reset also clears storage so head fields read zero.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign head                = mem_q[rd_ptr_q];
  assign opCode_o            = head.op_code;
  assign xOpCode_o           = head.x_op_code;
  assign address_o           = head.address;
  assign instructionFormat_o = head.format;
  assign reg1_o              = head.reg1;
  assign reg2_o              = head.reg2;
  assign reg3_o              = head.reg3;
  assign imm_o               = head.imm;
  assign bit1_o              = head.bit1;
  assign bit2_o              = head.bit2;

  assign enable_o   = (count_q != '0);
  assign stall_o    = (count_q >= STALL_C);
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_decoded_instruction_queue.sv
// Directed bench for decoded_instruction_queue with hand-computed expectations.
module tb_decoded_instruction_queue;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic [5:0]  opCode_i;
  logic [9:0]  xOpCode_i;
  logic [63:0] address_i;
  logic [4:0]  instructionFormat_i;
  logic [4:0]  reg1_i, reg2_i, reg3_i;
  logic [15:0] imm_i;
  logic        bit1_i, bit2_i;
  logic        flush_i;
  logic        readReady_i;
  logic        enable_o;
  logic [5:0]  opCode_o;
  logic [9:0]  xOpCode_o;
  logic [63:0] address_o;
  logic [4:0]  instructionFormat_o;
  logic [4:0]  reg1_o, reg2_o, reg3_o;
  logic [15:0] imm_o;
  logic        bit1_o, bit2_o;
  logic        stall_o;
  logic [3:0]  count_o;
  logic        overflow_o;

  int checks   = 0;
  int failures = 0;

  decoded_instruction_queue dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
    .opCode_i(opCode_i), .xOpCode_i(xOpCode_i), .address_i(address_i),
    .instructionFormat_i(instructionFormat_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .reg3_i(reg3_i), .imm_i(imm_i),
    .bit1_i(bit1_i), .bit2_i(bit2_i), .flush_i(flush_i),
    .readReady_i(readReady_i), .enable_o(enable_o),
    .opCode_o(opCode_o), .xOpCode_o(xOpCode_o), .address_o(address_o),
    .instructionFormat_o(instructionFormat_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .reg3_o(reg3_o), .imm_o(imm_o),
    .bit1_o(bit1_o), .bit2_o(bit2_o), .stall_o(stall_o),
    .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  initial begin
    reset_i = 1'b1; enable_i = 1'b0; flush_i = 1'b0; readReady_i = 1'b0;
    opCode_i = '0; xOpCode_i = '0; address_i = '0; instructionFormat_i = '0;
    reg1_i = '0; reg2_i = '0; reg3_i = '0; imm_i = '0; bit1_i = 1'b0; bit2_i = 1'b0;
    tick(); tick();
    chk("rst_enable", enable_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_address", address_o, 0);
    chk("rst_opcode", opCode_o, 0);
    reset_i = 1'b0;
    tick();

    // Three pushes, no pops
    for (int i = 0; i < 3; i++) begin
      enable_i = 1'b1; address_i = 64'h100 + 64'(4 * i); opCode_i = 6'(i + 1);
      imm_i = 16'hA000 + 16'(i); bit1_i = 1'b1;
      tick();
    end
    enable_i = 1'b0; bit1_i = 1'b0;
    chk("p3_count", count_o, 3);
    chk("p3_enable", enable_o, 1);
    chk("p3_addr0", address_o, 64'h100);
    chk("p3_imm0", imm_o, 16'hA000);
    chk("p3_bit1", bit1_o, 1);
    readReady_i = 1'b1;
    tick();
    chk("p3_addr1", address_o, 64'h104);
    tick();
    chk("p3_addr2", address_o, 64'h108);
    chk("p3_op2", opCode_o, 3);
    tick();
    chk("p3_empty_enable", enable_o, 0);
    chk("p3_empty_count", count_o, 0);
    readReady_i = 1'b0;

    // Fill to 8, watch stall threshold at 6
    for (int i = 0; i < 8; i++) begin
      enable_i = 1'b1; address_i = 64'h200 + 64'(i);
      tick();
      chk("fill_count", count_o, 64'(i + 1));
      chk("fill_stall", stall_o, (i + 1 >= 6) ? 1 : 0);
    end
    enable_i = 1'b1; address_i = 64'hDEAD;
    tick();
    chk("ovf_pulse", overflow_o, 1);
    chk("ovf_count", count_o, 8);
    enable_i = 1'b0;
    tick();
    chk("ovf_clear", overflow_o, 0);
    chk("ovf_head", address_o, 64'h200);

    // Full with push and pop together
    enable_i = 1'b1; readReady_i = 1'b1; address_i = 64'h300;
    tick();
    chk("fpp_count", count_o, 8);
    chk("fpp_overflow", overflow_o, 0);
    enable_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("fpp_head", address_o, 64'h201 + 64'(i));
      tick();
    end
    chk("fpp_new_entry", address_o, 64'h300);
    tick();
    chk("fpp_empty", count_o, 0);

    // Streaming 20 entries across pointer wrap
    for (int i = 0; i < 20; i++) begin
      enable_i = 1'b1; reg1_i = 5'(i);
      tick();
      chk("stream_reg1", reg1_o, 64'(i));
      chk("stream_count", count_o, 1);
    end
    enable_i = 1'b0;
    tick();
    chk("stream_drained", enable_o, 0);
    readReady_i = 1'b0;

    // Flush with a simultaneous push
    for (int i = 0; i < 5; i++) begin
      enable_i = 1'b1; opCode_i = 6'(i);
      tick();
    end
    chk("fl_loaded", count_o, 5);
    flush_i = 1'b1; opCode_i = 6'd7;
    tick();
    chk("fl_count", count_o, 0);
    chk("fl_enable", enable_o, 0);
    chk("fl_overflow", overflow_o, 0);
    flush_i = 1'b0; opCode_i = 6'd31;
    tick();
    enable_i = 1'b0;
    chk("fl_push_enable", enable_o, 1);
    chk("fl_push_op", opCode_o, 31);
    chk("fl_push_count", count_o, 1);
    readReady_i = 1'b1;
    tick();
    readReady_i = 1'b0;

    // Asynchronous reset mid-cycle with 4 entries loaded
    for (int i = 0; i < 4; i++) begin
      enable_i = 1'b1; opCode_i = 6'(i + 10); address_i = 64'h400 + 64'(i);
      tick();
    end
    chk("ar_loaded", count_o, 4);
    #3;
    reset_i = 1'b1;
    #1;
    chk("ar_enable", enable_o, 0);
    chk("ar_count", count_o, 0);
    chk("ar_opcode", opCode_o, 0);
    chk("ar_address", address_o, 0);
    tick(); tick();
    chk("ar_hold_enable", enable_o, 0);
    chk("ar_hold_count", count_o, 0);
    enable_i = 1'b0;
    reset_i = 1'b0;
    tick();
    chk("ar_after_count", count_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
